// File: rtl/seg7_display_ctrl.sv
// Multiplexed seven-segment display controller on the MIPS IO bus.
// It uses a double-buffered register bank and commits the shadow registers to the active registers once per frame.
module seg7_display_ctrl #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_BITS   = 17,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_write_en,
    input  logic [3:0]        io_addr,
    input  logic [31:0]       io_write_data,
    output logic [31:0]       io_read_data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_tick
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_MAX = {REFRESH_BITS{1'b1}};
    localparam logic [2:0]              LAST_DIGIT  = 3'(DIGITS - 1);
    localparam logic [7:0]              SEG_OFF     = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0]       AN_OFF      = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            4'hF: hex_to_seg = 7'h71;
            default: hex_to_seg = 7'h00;
        endcase
    endfunction

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [2:0]              r_digit;
    logic [7:0]              r_frame_cnt;
    logic                    r_pending;
    logic                    r_commit_q;
    logic [31:0]             r_sh_data, r_sh_raw_lo, r_sh_raw_hi;
    logic [27:0]             r_sh_ctrl;
    logic [31:0]             r_act_data, r_act_raw_lo, r_act_raw_hi;
    logic [27:0]             r_act_ctrl;

    logic                    w_slot_end, w_commit, w_wr_bank, w_lit;
    logic [31:0]             w_sh_data, w_sh_raw_lo, w_sh_raw_hi;
    logic [27:0]             w_sh_ctrl;
    logic [3:0]              w_phase, w_nibble;
    logic [63:0]             w_raw_all;
    logic [7:0]              w_raw_byte, w_seg_pos;
    logic [DIGITS-1:0]       w_an_pos;

    assign w_slot_end = (r_refresh == REFRESH_MAX);
    assign w_commit   = w_slot_end && (r_digit == LAST_DIGIT);

    // Shadow contents after this cycle's write; also what a commit loads, so commit-cycle writes bypass.
    always_comb begin
        w_sh_data   = r_sh_data;
        w_sh_ctrl   = r_sh_ctrl;
        w_sh_raw_lo = r_sh_raw_lo;
        w_sh_raw_hi = r_sh_raw_hi;
        w_wr_bank   = 1'b0;
        if (io_write_en) begin
            case (io_addr)
                4'd0: begin w_sh_data   = io_write_data;       w_wr_bank = 1'b1; end
                4'd1: begin w_sh_ctrl   = io_write_data[27:0]; w_wr_bank = 1'b1; end
                4'd2: begin w_sh_raw_lo = io_write_data;       w_wr_bank = 1'b1; end
                4'd3: begin w_sh_raw_hi = io_write_data;       w_wr_bank = 1'b1; end
                default: w_wr_bank = 1'b0;
            endcase
        end else begin
            w_wr_bank = 1'b0;
        end
    end

    // Refresh counter and digit index; the index wraps explicitly so non-power-of-2 DIGITS works.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh <= {REFRESH_BITS{1'b0}};
            r_digit   <= 3'd0;
        end else begin
            r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (w_slot_end) begin
                r_digit <= (r_digit == LAST_DIGIT) ? 3'd0 : r_digit + 3'd1;
            end
        end
    end

    // Register bank: shadow copies, active copies loaded at the frame boundary, pending flag and frame count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_data    <= 32'h0;
            r_sh_ctrl    <= 28'h F00_0000;
            r_sh_raw_lo  <= 32'h0;
            r_sh_raw_hi  <= 32'h0;
            r_act_data   <= 32'h0;
            r_act_ctrl   <= 28'hF00_0000;
            r_act_raw_lo <= 32'h0;
            r_act_raw_hi <= 32'h0;
            r_pending    <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_commit_q   <= 1'b0;
        end else begin
            r_sh_data   <= w_sh_data;
            r_sh_ctrl   <= w_sh_ctrl;
            r_sh_raw_lo <= w_sh_raw_lo;
            r_sh_raw_hi <= w_sh_raw_hi;
            r_commit_q  <= w_commit;
            if (w_commit) begin
                r_act_data   <= w_sh_data;
                r_act_ctrl   <= w_sh_ctrl;
                r_act_raw_lo <= w_sh_raw_lo;
                r_act_raw_hi <= w_sh_raw_hi;
                r_pending    <= 1'b0;
                r_frame_cnt  <= r_frame_cnt + 8'd1;
            end else if (w_wr_bank) begin
                r_pending    <= 1'b1;
            end
        end
    end

    assign w_phase    = r_refresh[REFRESH_BITS-1 -: 4];
    assign w_raw_all  = {r_act_raw_hi, r_act_raw_lo};
    assign w_nibble   = r_act_data[{r_digit, 2'b00} +: 4];
    assign w_raw_byte = w_raw_all[{r_digit, 3'b000} +: 8];
    assign w_lit      = (w_phase <= r_act_ctrl[27:24]) && !r_act_ctrl[5'(r_digit)];

    // Segment pattern for the current digit before polarity is applied.
    always_comb begin
        w_seg_pos = 8'h00;
        if (!w_lit) begin
            w_seg_pos = 8'h00;
        end else if (r_act_ctrl[5'd8 + 5'(r_digit)]) begin
            w_seg_pos = w_raw_byte;
        end else begin
            w_seg_pos = {r_act_ctrl[5'd16 + 5'(r_digit)], hex_to_seg(w_nibble)};
        end
    end

    always_comb begin
        w_an_pos = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            w_an_pos[i] = w_lit && (r_digit == 3'(i));
        end
    end

    // The output stage is one cycle behind the scan state; frame_tick is delayed to line up with digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= SEG_ACTIVE_LOW ? ~w_seg_pos : w_seg_pos;
            an         <= AN_ACTIVE_LOW ? ~w_an_pos : w_an_pos;
            frame_tick <= r_commit_q;
        end
    end

    always_comb begin
        io_read_data = 32'h0;
        case (io_addr)
            4'd0:    io_read_data = r_sh_data;
            4'd1:    io_read_data = {4'h0, r_sh_ctrl};
            4'd2:    io_read_data = r_sh_raw_lo;
            4'd3:    io_read_data = r_sh_raw_hi;
            4'd4:    io_read_data = {20'h0, r_digit, r_pending, r_frame_cnt};
            default: io_read_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomised bench for seg7_display_ctrl at DIGITS=4 and DIGITS=6 with REFRESH_BITS=4.
// A cycle-count reference model predicts the outputs and the readback for both instances.
module tb_seg7_display_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        io_write_en = 1'b0;
    logic [3:0]  io_addr = 4'd0;
    logic [31:0] io_write_data = 32'h0;
    logic [31:0] rd4, rd6;
    logic [7:0]  seg4, seg6;
    logic [3:0]  an4, an4_on;
    logic [5:0]  an6, an6_on;
    logic        tick4, tick6;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign an4_on = ~an4;
    assign an6_on = ~an6;

    seg7_display_ctrl #(.DIGITS(4), .REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n), .io_write_en(io_write_en), .io_addr(io_addr),
        .io_write_data(io_write_data), .io_read_data(rd4), .seg(seg4), .an(an4), .frame_tick(tick4));

    seg7_display_ctrl #(.DIGITS(6), .REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut6 (
        .clk(clk), .reset_n(reset_n), .io_write_en(io_write_en), .io_addr(io_addr),
        .io_write_data(io_write_data), .io_read_data(rd6), .seg(seg6), .an(an6), .frame_tick(tick6));

    logic [6:0]  hex_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [31:0] sh_data, sh_ctrl, sh_lo, sh_hi;
    logic [31:0] ac_data [2];
    logic [31:0] ac_ctrl [2];
    logic [31:0] ac_lo [2];
    logic [31:0] ac_hi [2];
    bit          pend [2];
    int          frames [2];
    int          t;
    int          on_cnt [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nd(input int m);
        return (m == 0) ? 4 : 6;
    endfunction

    function automatic int cur_digit(input int m);
        return (t / 16) % nd(m);
    endfunction

    function automatic void model_reset();
        sh_data = 32'h0; sh_ctrl = 32'h0F00_0000; sh_lo = 32'h0; sh_hi = 32'h0;
        for (int m = 0; m < 2; m++) begin
            ac_data[m] = 32'h0; ac_ctrl[m] = 32'h0F00_0000; ac_lo[m] = 32'h0; ac_hi[m] = 32'h0;
            pend[m] = 1'b0; frames[m] = 0;
        end
        t = 0;
    endfunction

    function automatic void model_edge(input bit we, input logic [3:0] a, input logic [31:0] wd);
        if (we) begin
            case (a)
                4'd0: sh_data = wd;
                4'd1: sh_ctrl = wd & 32'h0FFF_FFFF;
                4'd2: sh_lo = wd;
                4'd3: sh_hi = wd;
                default: ;
            endcase
            if (a < 4'd4) begin
                pend[0] = 1'b1; pend[1] = 1'b1;
            end
        end
        t++;
        for (int m = 0; m < 2; m++) begin
            if (t % (16 * nd(m)) == 0) begin
                ac_data[m] = sh_data; ac_ctrl[m] = sh_ctrl; ac_lo[m] = sh_lo; ac_hi[m] = sh_hi;
                pend[m] = 1'b0;
                frames[m] = (frames[m] + 1) % 256;
            end
        end
    endfunction

    function automatic bit exp_lit(input int m);
        int d = cur_digit(m);
        int br = int'(ac_ctrl[m][27:24]);
        return ((t % 16) <= br) && (ac_ctrl[m][d] == 1'b0);
    endfunction

    function automatic logic [7:0] exp_seg(input int m);
        int d = cur_digit(m);
        logic [63:0] raw = {ac_hi[m], ac_lo[m]};
        if (!exp_lit(m)) return 8'h00;
        if (ac_ctrl[m][8 + d]) return raw[8 * d +: 8];
        return {ac_ctrl[m][16 + d], hex_tab[ac_data[m][4 * d +: 4]]};
    endfunction

    function automatic logic [7:0] exp_an(input int m);
        return exp_lit(m) ? 8'(1 << cur_digit(m)) : 8'h00;
    endfunction

    function automatic logic [31:0] exp_rd(input int m, input logic [3:0] a);
        case (a)
            4'd0: return sh_data;
            4'd1: return sh_ctrl;
            4'd2: return sh_lo;
            4'd3: return sh_hi;
            4'd4: return {20'h0, 3'(cur_digit(m)), pend[m], 8'(frames[m])};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input bit we, input logic [3:0] a, input logic [31:0] wd);
        logic [7:0] es [2];
        logic [7:0] ea [2];
        bit         et [2];
        io_write_en = we; io_addr = a; io_write_data = wd;
        for (int m = 0; m < 2; m++) begin
            es[m] = exp_seg(m);
            ea[m] = exp_an(m);
            et[m] = (t > 0) && (t % (16 * nd(m)) == 0);
        end
        @(posedge clk);
        model_edge(we, a, wd);
        #1;
        check_eq("seg4", 32'(8'(~seg4)), 32'(es[0]));
        check_eq("an4", {28'h0, an4_on}, 32'(ea[0]));
        check_eq("tick4", 32'(tick4), 32'(et[0]));
        check_eq("seg6", 32'(8'(~seg6)), 32'(es[1]));
        check_eq("an6", {26'h0, an6_on}, 32'(ea[1]));
        check_eq("tick6", 32'(tick6), 32'(et[1]));
        check_eq("rd4", rd4, exp_rd(0, a));
        check_eq("rd6", rd6, exp_rd(1, a));
        io_write_en = 1'b0;
    endtask

    task automatic check_inactive(input string tag);
        check_eq({tag, "_seg4"}, 32'(seg4), 32'h0000_00FF);
        check_eq({tag, "_an4"}, 32'(an4), 32'h0000_000F);
        check_eq({tag, "_seg6"}, 32'(seg6), 32'h0000_00FF);
        check_eq({tag, "_an6"}, 32'(an6), 32'h0000_003F);
        check_eq({tag, "_tick"}, 32'({tick4, tick6}), 32'h0);
        check_eq({tag, "_stat"}, rd4 | rd6, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        io_write_en = 1'b0; io_addr = 4'd4;
        #2 reset_n = 1'b0;
        #1 check_inactive(tag);
        repeat (2) @(negedge clk);
        check_inactive(tag);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic align_frame_start();
        while ((t % 64) != 1) step(1'b0, 4'd4, 32'h0);
    endtask

    initial begin
        model_reset();
        io_addr = 4'd4;
        #2 reset_n = 1'b0;
        #1 check_inactive("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 4'd4, 32'h0);
        check_eq("first_out", {20'h0, seg4, an4}, {20'h0, 8'hC0, 4'hE});
        repeat (70) step(1'b0, 4'd4, 32'h0);

        while ((t % 64) != 20) step(1'b0, 4'd0, 32'h0);
        step(1'b1, 4'd0, 32'h0000_4321);
        check_eq("db_pend", 32'(rd4[8]), 32'h1);
        align_frame_start();
        check_eq("db_dig0", {23'h0, tick4, seg4}, {23'h0, 1'b1, 8'hF9});
        check_eq("db_stat", 32'({rd4[8], rd4[7:0]}), 32'(9'h002));

        while (((t + 1) % 64) != 0) step(1'b0, 4'd4, 32'h0);
        step(1'b1, 4'd0, 32'h0000_00A5);
        step(1'b0, 4'd4, 32'h0);
        check_eq("cc_dig0", 32'(seg4), 32'h0000_0092);
        check_eq("cc_pend", 32'(rd4[8]), 32'h0);

        step(1'b1, 4'd1, 32'h0F01_0402);
        step(1'b1, 4'd2, 32'h0080_0000);
        align_frame_start();
        on_cnt = '{0, 0, 0, 0};
        repeat (64) begin
            step(1'b0, 4'd4, 32'h0);
            if (an4[1] == 1'b0) on_cnt[1]++;
            if (an4 == 4'hB && seg4 == 8'h7F) on_cnt[2]++;
            if (an4 == 4'hE && seg4[7] == 1'b0) on_cnt[0]++;
        end
        check_eq("mode_blank", 32'(on_cnt[1]), 32'd0);
        check_eq("mode_raw", 32'(on_cnt[2]), 32'd16);
        check_eq("mode_dp", 32'(on_cnt[0]), 32'd16);

        for (int b = 0; b < 2; b++) begin
            step(1'b1, 4'd1, (b == 0) ? 32'h0300_0000 : 32'h0000_0000);
            align_frame_start();
            on_cnt = '{0, 0, 0, 0};
            repeat (64) begin
                step(1'b0, 4'd4, 32'h0);
                for (int d = 0; d < 4; d++) if (an4[d] == 1'b0) on_cnt[d]++;
            end
            for (int d = 0; d < 4; d++) check_eq("pwm_on", 32'(on_cnt[d]), (b == 0) ? 32'd4 : 32'd1);
        end

        while ((t % 16) != 7) step(1'b0, 4'd4, 32'h0);
        do_reset("midrst");

        repeat (2500) begin
            if ($urandom_range(0, 599) == 0) do_reset("rndrst");
            step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised multiplexed seven-segment display controller on the MIPS memory-mapped IO bus. It replaces the fixed four-digit, write-only display register with a bank of registers that can be read back. The bank supports 1–8 digits, per-digit hex-decode or raw-segment mode, blanking, decimal points, and PWM brightness. Display data is double-buffered so the visible image only changes on a frame boundary, with no tearing.

## Interface
Parameters:
- DIGITS, 4, number of digits driven; legal range 1..8.
- REFRESH_BITS, 17, one digit slot lasts 2^REFRESH_BITS clk cycles; minimum 4.
- SEG_ACTIVE_LOW, 1, 1 means segment outputs are driven low to light.
- AN_ACTIVE_LOW, 1, 1 means anode outputs are driven low to enable.

Ports:
- clk  in  1  system clock. Only one clock is used.
- reset_n  in  1  asynchronous, active-low reset.
- io_write_en  in  1  register write strobe, sampled on the rising edge of clk.
- io_addr  in  4  register address, shared by reads and writes.
- io_write_data  in  32  write data.
- io_read_data  out  32  combinational readback of the register at io_addr.
- seg  out  8  {dp,g,f,e,d,c,b,a}, registered.
- an  out  DIGITS  one anode per digit, registered.
- frame_tick  out  1  one-cycle pulse on each frame commit, registered.

## Operation
Register map (io_addr):
- 0 DATA: nibble i ([4i+3:4i]) holds the hex value for digit i. This register is a shadow.
- 1 CTRL: [7:0] blank mask, [15:8] raw-mode mask, [23:16] dp mask, [27:24] brightness. This register is a shadow.
- 2 RAW_LO: byte i holds the raw segments {dp,g..a} for digits 0–3. This register is a shadow.
- 3 RAW_HI: the same as RAW_LO for digits 4–7. This register is a shadow.
- 4 STATUS: read-only. [7:0] frame count (wraps at 255), [8] pending flag, [11:9] current digit index.
- Other addresses: reads return 0 and writes are ignored.
- Mask and byte bits at or above DIGITS are stored and read back, but have no effect.

Double buffering:
- Writes update only the shadow registers and set pending=1. Reads of addresses 0–3 return the shadow registers.
- Commit: on the cycle the digit index wraps from DIGITS-1 to 0, all active registers are loaded from the shadow registers, pending clears, frame count increments and frame_tick pulses.
- A write in the commit cycle is included in that commit, i.e. the new data bypasses into the active registers, and pending ends that cycle at 0.

Scan:
- refresh counter: REFRESH_BITS wide, free-running.
- Digit index: 0..DIGITS-1. It advances when the refresh counter wraps to 0 and wraps from DIGITS-1 to 0; this must also hold when DIGITS is not a power of 2.
- PWM phase = refresh counter[REFRESH_BITS-1 -: 4]. The digit is lit when phase <= brightness, giving a duty of (brightness+1)/16.
- Per digit i (before polarity is applied):
  - blank[i]=1, or outside the PWM window: anode off, segments all off.
  - raw[i]=1: seg = raw byte i, and the dp mask is ignored.
  - otherwise: seg[6:0] = hex decode of nibble i (0–F, standard a–g patterns), and seg[7] = dp[i].
- Hex decode of 0 gives a–f on and g off. The raw pattern for "0" is 8'h3F.
- Only the current digit's anode may be enabled. At most one anode is ever on.

Reset (reset_n=0, asynchronous):
- Counters, index and frame count are cleared to 0.
- All shadow and active registers are cleared to 0, except brightness, which resets to 15 in both copies.
- pending=0, frame_tick=0.
- seg = all segments off and an = all anodes off, after polarity is applied.
- When reset is asserted mid-frame, outputs go inactive immediately and the pending write is lost.

## Timing
- Output latency: seg and an reflect the index, counter and active registers one cycle after they change.
- Digit slot: 2^REFRESH_BITS cycles. Frame: DIGITS × 2^REFRESH_BITS cycles.
- Write-to-display latency: a write becomes visible in the first output cycle of the next frame.
  - Worst case is one full frame plus one cycle.
  - A write in the commit cycle itself is visible after one cycle.
- io_read_data is combinational: a read returns a write's data in the cycle after the write.
- frame_tick is asserted in the same cycle that digit 0 first appears on the outputs.
- After reset_n deasserts, the first digit 0 output is seen on the cycle after the first clk edge.

## Test plan
Scenarios use DIGITS=4, REFRESH_BITS=4 and active-low polarity unless stated otherwise.
- Reset: hold reset_n=0, then release. Required: seg=8'hFF and an=4'hF while in reset. After release, an cycles 1110→1101→1011→0111 every 16 cycles, and seg[6:0]=~7'h3F (hex 0).
- Double buffer: write DATA=32'h0000_4321 mid-frame. Required: STATUS[8]=1 and the displayed data does not change until the wrap. At the wrap, frame_tick pulses and digits read 1,2,3,4 (seg[6:0]=~7'h06 on digit 0); STATUS[8]=0 and the frame count has incremented.
- Write in the commit cycle: issue a write in the same cycle as the index wrap. Required: the new value shows in digit 0 of that frame, and pending=0 afterward.
- Modes: CTRL with blank=8'h02, raw=8'h04, dp=8'h01, and RAW_LO byte2=8'h80. Required: digit 1 anode never enables; digit 2 shows seg=8'h7F; digit 0 shows its dp lit.
- PWM: brightness=3. Required: each anode is enabled for exactly 4 of its 16 slot cycles; with brightness 0, exactly 1 of 16.
- Non-power-of-2 and reset: with DIGITS=6, the index sequence is 0..5 then 0, and the index never reaches 6 or 7. Asserting reset_n low mid-slot forces all outputs inactive in the same cycle.
